mem_reader: RTL and testbench

MEM_READER -- requirements
Module: mem_reader

---
 rtl/mem_reader.sv | 144 ++++++++++++++
 tb/tb_mem_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_reader.sv
// Streams address pairs from a dual-read memory into a 2-entry output FIFO.
// One pair per cycle with out_ready high; issues are credit-limited so the FIFO never overflows.
module mem_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_1,
    input  logic [ADDR_WIDTH-1:0] base_2,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr_1,
    output logic [ADDR_WIDTH-1:0] mem_addr_2,
    input  logic [DATA_WIDTH-1:0] mem_data_1,
    input  logic [DATA_WIDTH-1:0] mem_data_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] fifo_1 [2];
    logic [DATA_WIDTH-1:0] fifo_2 [2];
    logic [1:0]            fifo_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  inflight_last;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] b1_q;
    logic [ADDR_WIDTH-1:0] b2_q;

    logic                  pop;
    logic [1:0]            credit;
    logic                  issue;
    logic                  last_issue;
    logic [ADDR_WIDTH:0]   req_cnt;

    assign out_valid  = (occ != 2'd0);
    assign out_data_1 = fifo_1[rd_ptr];
    assign out_data_2 = fifo_2[rd_ptr];
    assign out_last   = out_valid & fifo_last[rd_ptr];
    assign pop        = out_valid & out_ready;
    // Occupancy after this edge's capture and pop; doubles as the next occ value.
    assign credit     = occ + {1'b0, inflight} - {1'b0, pop};
    assign issue      = (state == ISSUE) && (credit < 2'd2);
    assign last_issue = (idx == cnt - 1'b1);
    assign req_cnt    = (count > MAX_CNT) ? MAX_CNT : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_addr_1    <= '0;
            mem_addr_2    <= '0;
            fifo_1[0]     <= '0;
            fifo_1[1]     <= '0;
            fifo_2[0]     <= '0;
            fifo_2[1]     <= '0;
            fifo_last     <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            occ           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            b1_q          <= '0;
            b2_q          <= '0;
        end else begin
            occ      <= credit;
            inflight <= 1'b0;
            done     <= 1'b0;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Memory data for last cycle's issue is valid now.
            if (inflight) begin
                fifo_1[wr_ptr]    <= mem_data_1;
                fifo_2[wr_ptr]    <= mem_data_2;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (req_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            b1_q          <= base_1;
                            b2_q          <= base_2;
                            cnt           <= req_cnt;
                            mem_addr_1    <= base_1;
                            mem_addr_2    <= base_2;
                            idx           <= (ADDR_WIDTH+1)'(1);
                            inflight      <= 1'b1;
                            inflight_last <= (req_cnt == (ADDR_WIDTH+1)'(1));
                            state         <= (req_cnt == (ADDR_WIDTH+1)'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        mem_addr_1    <= b1_q + idx[ADDR_WIDTH-1:0];
                        mem_addr_2    <= b2_q + idx[ADDR_WIDTH-1:0];
                        inflight      <= 1'b1;
                        inflight_last <= last_issue;
                        idx           <= idx + 1'b1;
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: streaming, wrap-around, backpressure, zero count,
// start while busy and reset mid-transfer, against a memory holding mem[k]=k*3.
module tb_mem_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_1 = '0;
    logic [3:0]  base_2 = '0;
    logic [4:0]  count = '0;
    logic        busy, done;
    logic [3:0]  mem_addr_1, mem_addr_2;
    logic [15:0] mem_data_1, mem_data_2;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data_1, out_data_2;
    logic        out_last;

    logic [15:0] mem [16];
    int          passed = 0;
    int          total = 0;
    int          failed = 0;
    int          done_cnt = 0;
    logic [5:0]  stall_pat = 6'b101001;  // bit c%6 is out_ready: 1,0,0,1,0,1

    mem_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_1(base_1), .base_2(base_2),
        .count(count), .busy(busy), .done(done),
        .mem_addr_1(mem_addr_1), .mem_addr_2(mem_addr_2),
        .mem_data_1(mem_data_1), .mem_data_2(mem_data_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_1(out_data_1), .out_data_2(out_data_2), .out_last(out_last)
    );

    always #5 clk = ~clk;

    assign mem_data_1 = mem[mem_addr_1];
    assign mem_data_2 = mem[mem_addr_2];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mexp(input logic [3:0] b, input int k);
        logic [3:0] a;
        a = b + 4'(k);
        return {12'd0, a} * 16'd3;
    endfunction

    task automatic run_xfer(input logic [3:0] b1, input logic [3:0] b2, input logic [4:0] n,
                            input bit stall, input bit restart);
        int k;
        int dc0;
        bit fin;
        bit held;
        logic [15:0] h1, h2;
        k = 0; fin = 0; held = 0; h1 = '0; h2 = '0;
        dc0 = done_cnt;
        base_1 = b1; base_2 = b2; count = n; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("accept_busy", busy, 1);
        for (int c = 0; c < 200; c++) begin
            if (!fin) begin
                if (held) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_d1", out_data_1, h1);
                    chk("hold_d2", out_data_2, h2);
                    held = 0;
                end
                if (done) begin
                    fin = 1;
                end else begin
                    start = (restart && c == 2);
                    count = (restart && c == 2) ? 5'd2 : n;
                    out_ready = stall ? stall_pat[c % 6] : 1'b1;
                    if (out_valid && out_ready) begin
                        chk("pair_d1", out_data_1, mexp(b1, k));
                        chk("pair_d2", out_data_2, mexp(b2, k));
                        chk("pair_last", out_last, (k == int'(n) - 1));
                        k++;
                    end else if (out_valid) begin
                        held = 1; h1 = out_data_1; h2 = out_data_2;
                    end
                    step();
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("finished_in_budget", fin, 1);
        chk("pair_count", k, n);
        step();
        chk("done_once", done_cnt - dc0, 1);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 3);

        // Reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr1", mem_addr_1, 0);
        chk("rst_addr2", mem_addr_2, 0);
        chk("rst_d1", out_data_1, 0);
        chk("rst_d2", out_data_2, 0);

        // Streaming; start honoured on the first edge after reset release
        rst = 1'b0; base_1 = 4'd2; base_2 = 4'd8; count = 5'd4; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("s_busy", busy, 1);
        chk("s_addr1", mem_addr_1, 2);
        chk("s_addr2", mem_addr_2, 8);
        chk("s_valid0", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s_valid", out_valid, 1);
            chk("s_d1", out_data_1, 6 + 3 * i);
            chk("s_d2", out_data_2, 24 + 3 * i);
            chk("s_last", out_last, (i == 3));
            chk("s_nodone", done, 0);
        end
        step();
        chk("s_done", done, 1);
        chk("s_done_busy", busy, 1);
        chk("s_done_valid", out_valid, 0);
        step();
        chk("s_done_clr", done, 0);
        chk("s_idle", busy, 0);
        chk("s_done_cnt", done_cnt, 1);

        // Wrap-around
        run_xfer(4'd14, 4'd0, 5'd4, 1'b0, 1'b0);
        chk("w_addr1_hold", mem_addr_1, 1);
        chk("w_addr2_hold", mem_addr_2, 3);

        // Zero count
        dc = done_cnt;
        count = 5'd0; base_1 = 4'd9; base_2 = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        chk("z_busy", busy, 1);
        chk("z_done", done, 1);
        chk("z_valid", out_valid, 0);
        step();
        chk("z_busy_clr", busy, 0);
        chk("z_done_clr", done, 0);
        chk("z_valid2", out_valid, 0);
        chk("z_addr1", mem_addr_1, 1);
        chk("z_addr2", mem_addr_2, 3);
        chk("z_done_cnt", done_cnt - dc, 1);

        // Backpressure
        run_xfer(4'd3, 4'd9, 5'd6, 1'b1, 1'b0);

        // Start while busy
        run_xfer(4'd0, 4'd10, 5'd5, 1'b0, 1'b1);

        // Reset mid-transfer after two pairs accepted
        base_1 = 4'd0; base_2 = 4'd4; count = 5'd8; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_valid", out_valid, 0);
        chk("r_last", out_last, 0);
        chk("r_addr1", mem_addr_1, 0);
        chk("r_addr2", mem_addr_2, 0);
        chk("r_d1", out_data_1, 0);
        chk("r_d2", out_data_2, 0);
        dc = done_cnt;
        step(); step(); step();
        chk("r_no_done", done_cnt - dc, 0);
        rst = 1'b0;
        step();
        chk("r_still_idle", busy, 0);
        run_xfer(4'd7, 4'd12, 5'd3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
